// File: rtl/posit_mult_unit_if.sv
// Operand/result bundle for the posit multiplier: start-qualified operands in,
// registered product and flags out.
interface posit_mult_unit_if #(
  parameter int N = 32
);
  logic [N-1:0] in1;
  logic [N-1:0] in2;
  logic         start;
  logic [N-1:0] result;
  logic         inf;
  logic         zero;
  logic         done;

  modport master (
    output in1, in2, start,
    input  result, inf, zero, done
  );

  modport slave (
    input  in1, in2, start,
    output result, inf, zero, done
  );
endinterface

// File: rtl/posit_mult_unit.sv
// Posit<N,es> multiplier: combinational decode/multiply/round-to-nearest-even,
// one output register stage; done is a registered copy of start.
module posit_mult_unit #(
  parameter int N  = 32,
  parameter int Bs = $clog2(N),
  parameter int es = 2
) (
  input logic              clk,
  input logic              rst,
  posit_mult_unit_if.slave bus
);

  localparam int SW = Bs + es + 2;
  localparam int MW = N - es;
  localparam int FW = 2 * MW - 1;
  localparam int VW = 2 + es + FW + N - 2;
  localparam logic signed [SW:0] SC_MAX = (SW + 1)'((N - 2) << es);
  localparam logic signed [SW:0] SC_MIN = -SC_MAX;
  localparam logic [N-1:0] NAR    = {1'b1, {(N - 1){1'b0}}};
  localparam logic [N-1:0] MAXPOS = {1'b0, {(N - 1){1'b1}}};
  localparam logic [N-1:0] MINPOS = {{(N - 1){1'b0}}, 1'b1};
  localparam logic [Bs:0]  ONE_M  = (Bs + 1)'(1);
  localparam logic [SW-1:0] ONE_K = SW'(1);

  function automatic void decode(
    input  logic [N-1:0]         w,
    output logic                 sgn,
    output logic signed [SW-1:0] scale,
    output logic [MW-1:0]        mant
  );
    logic [N-1:0]  x;
    logic [N-2:0]  rem;
    logic [N-2:0]  rest;
    logic          rc;
    logic          run_on;
    logic [Bs:0]   m;
    logic [SW-1:0] k;
    sgn    = w[N-1];
    x      = sgn ? -w : w;
    rem    = x[N-2:0];
    rc     = rem[N-2];
    m      = '0;
    run_on = 1'b1;
    for (int i = N - 2; i >= 0; i--) begin
      if (run_on && (rem[i] == rc)) m = m + ONE_M;
      else                          run_on = 1'b0;
    end
    // Drop the regime run and its terminator; exponent/fraction come out zero-padded.
    rest  = rem << (m + ONE_M);
    k     = rc ? (SW'(m) - ONE_K) : -SW'(m);
    scale = {k[SW-es-1:0], rest[N-2 -: es]};
    mant  = {1'b1, rest[N-es-2:0]};
  endfunction

  logic                 w_s1, w_s2;
  logic signed [SW-1:0] w_sc1, w_sc2;
  logic [MW-1:0]        w_m1, w_m2;
  logic [2*MW-1:0]      w_prod;
  logic [FW-1:0]        w_frac;
  logic signed [SW:0]   w_sc;
  logic [Bs:0]          w_sh;
  logic [VW-1:0]        w_v, w_vs;
  logic [N-2:0]         w_top;
  logic                 w_guard, w_sticky;
  logic [N-1:0]         w_mag, w_res;
  logic                 w_nar, w_zero;

  logic [N-1:0] r_result;
  logic         r_inf, r_zero, r_done;

  always_comb begin
    decode(bus.in1, w_s1, w_sc1, w_m1);
    decode(bus.in2, w_s2, w_sc2, w_m2);
    w_prod = {{MW{1'b0}}, w_m1} * {{MW{1'b0}}, w_m2};
    w_frac = w_prod[2*MW-1] ? w_prod[FW-1:0] : {w_prod[FW-2:0], 1'b0};
    w_sc   = {w_sc1[SW-1], w_sc1} + {w_sc2[SW-1], w_sc2} + {{SW{1'b0}}, w_prod[2*MW-1]};
    // Regime seed 10 / 01 followed by an arithmetic shift replicates the run bit.
    w_sh   = w_sc[SW] ? ~w_sc[Bs+es:es] : w_sc[Bs+es:es];
    w_v    = {~w_sc[SW], w_sc[SW], w_sc[es-1:0], w_frac, {(N - 2){1'b0}}};
    w_vs   = $signed(w_v) >>> w_sh;
    w_top    = w_vs[VW-1 -: N-1];
    w_guard  = w_vs[VW-N];
    w_sticky = |w_vs[VW-N-1:0];
    w_mag    = {1'b0, w_top} + {{(N - 1){1'b0}}, w_guard & (w_sticky | w_top[0])};
    if ((w_sc > SC_MAX) || w_mag[N-1]) w_mag = MAXPOS;
    else if (w_sc < SC_MIN)            w_mag = MINPOS;

    w_nar  = (bus.in1 == NAR) || (bus.in2 == NAR);
    w_zero = ((bus.in1 == '0) || (bus.in2 == '0)) && !w_nar;
    if (w_nar)       w_res = NAR;
    else if (w_zero) w_res = '0;
    else             w_res = (w_s1 ^ w_s2) ? -w_mag : w_mag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_inf    <= 1'b0;
      r_zero   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_result <= w_res;
      r_inf    <= w_nar;
      r_zero   <= w_zero;
      r_done   <= bus.start;
    end
  end

  assign bus.result = r_result;
  assign bus.inf    = r_inf;
  assign bus.zero   = r_zero;
  assign bus.done   = r_done;

endmodule

// File: tb/tb_posit_mult_unit.sv
// Directed and streamed checks of posit_mult_unit against hand values and a
// bit-serial posit<32,2> reference.
module tb_posit_mult_unit;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  posit_mult_unit_if #(.N(32)) bus ();

  posit_mult_unit #(.N(32), .Bs(5), .es(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic st);
    @(negedge clk);
    bus.in1   = a;
    bus.in2   = b;
    bus.start = st;
    @(posedge clk);
    #1;
  endtask

  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] e_res, input logic e_inf, input logic e_zero);
    apply(a, b, 1'b1);
    chk({tag, ".res"},  bus.result, e_res);
    chk({tag, ".inf"},  {31'b0, bus.inf},  {31'b0, e_inf});
    chk({tag, ".zero"}, {31'b0, bus.zero}, {31'b0, e_zero});
    chk({tag, ".done"}, {31'b0, bus.done}, 32'd1);
  endtask

  // Reference decode: walk the word bit by bit; mantissa has 28 fraction bits.
  function automatic void mdec(input logic [31:0] w, output bit s, output int sc,
                               output longint unsigned m);
    logic [31:0] x;
    int i, run, e;
    bit rc;
    s   = w[31];
    x   = s ? (~w + 32'd1) : w;
    rc  = x[30];
    run = 0;
    i   = 30;
    while (i >= 0 && x[i] == rc) begin run++; i--; end
    i--;
    e = 0;
    for (int j = 0; j < 2; j++) begin e = e * 2 + ((i >= 0) ? int'(x[i]) : 0); i--; end
    m = 1;
    for (int j = 0; j < 28; j++) begin m = m * 2 + ((i >= 0) ? longint'(x[i]) : 0); i--; end
    sc = (rc ? run - 1 : -run) * 4 + e;
  endfunction

  function automatic logic [31:0] mmul(input logic [31:0] a, input logic [31:0] b,
                                       output bit inf, output bit zr);
    bit sa, sb, g, st;
    int sca, scb, sc, k, e, fb;
    longint unsigned ma, mb, p;
    logic [31:0] mag;
    bit q[$];
    inf = 0;
    zr  = 0;
    if (a == 32'h80000000 || b == 32'h80000000) begin inf = 1; return 32'h80000000; end
    if (a == 32'h0 || b == 32'h0) begin zr = 1; return 32'h0; end
    mdec(a, sa, sca, ma);
    mdec(b, sb, scb, mb);
    p  = ma * mb;
    sc = sca + scb;
    fb = 56;
    if (p >= (64'd1 << 57)) begin fb = 57; sc++; end
    if (sc > 120)       mag = 32'h7FFFFFFF;
    else if (sc < -120) mag = 32'h00000001;
    else begin
      k = (sc >= 0) ? sc / 4 : -((3 - sc) / 4);
      e = sc - 4 * k;
      if (k >= 0) begin
        for (int j = 0; j <= k; j++) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        for (int j = 0; j < -k; j++) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      q.push_back(e[1]);
      q.push_back(e[0]);
      for (int j = fb - 1; j >= 0; j--) q.push_back(p[j]);
      mag = 0;
      g   = 0;
      st  = 0;
      for (int j = 0; j < q.size(); j++) begin
        if (j < 31)       mag = {mag[30:0], q[j]};
        else if (j == 31) g = q[j];
        else              st = st | q[j];
      end
      if (g && (st || mag[0])) mag = mag + 32'd1;
      if (mag > 32'h7FFFFFFF) mag = 32'h7FFFFFFF;
      if (mag == 32'h0) mag = 32'h00000001;
    end
    return (sa ^ sb) ? (~mag + 32'd1) : mag;
  endfunction

  logic [31:0] sa_q[$];
  logic [31:0] sb_q[$];

  initial begin
    bus.in1   = '0;
    bus.in2   = '0;
    bus.start = 1'b0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.res",  bus.result, 32'h0);
    chk("rst.inf",  {31'b0, bus.inf},  32'd0);
    chk("rst.zero", {31'b0, bus.zero}, 32'd0);
    chk("rst.done", {31'b0, bus.done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    op("one_x_one", 32'h40000000, 32'h40000000, 32'h40000000, 1'b0, 1'b0);

    // Reset in the middle of traffic wins over start.
    @(negedge clk);
    rst       = 1'b1;
    bus.in1   = 32'h48000000;
    bus.in2   = 32'h48000000;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst.res",  bus.result, 32'h0);
    chk("midrst.done", {31'b0, bus.done}, 32'd0);
    chk("midrst.inf",  {31'b0, bus.inf},  32'd0);
    @(negedge clk);
    rst = 1'b0;

    op("two_x_two",     32'h48000000, 32'h48000000, 32'h50000000, 1'b0, 1'b0);
    op("1p5_sq",        32'h44000000, 32'h44000000, 32'h49000000, 1'b0, 1'b0);
    op("neg1_x_two",    32'hC0000000, 32'h48000000, 32'hB8000000, 1'b0, 1'b0);
    op("neg_x_neg",     32'hC0000000, 32'hC0000000, 32'h40000000, 1'b0, 1'b0);
    op("four_sq",       32'h50000000, 32'h50000000, 32'h60000000, 1'b0, 1'b0);
    op("quarter_sq",    32'h30000000, 32'h30000000, 32'h20000000, 1'b0, 1'b0);
    op("four_x_qtr",    32'h50000000, 32'h30000000, 32'h40000000, 1'b0, 1'b0);
    op("maxpos_sq",     32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0);
    op("minpos_sq",     32'h00000001, 32'h00000001, 32'h00000001, 1'b0, 1'b0);
    op("tie_up",        32'h40000001, 32'h44000000, 32'h44000002, 1'b0, 1'b0);
    op("tie_even",      32'h40000003, 32'h44000000, 32'h44000004, 1'b0, 1'b0);
    op("zero_x_two",    32'h00000000, 32'h48000000, 32'h00000000, 1'b0, 1'b1);
    op("nar_x_zero",    32'h80000000, 32'h00000000, 32'h80000000, 1'b1, 1'b0);
    op("nar_x_one",     32'h80000000, 32'h40000000, 32'h80000000, 1'b1, 1'b0);

    sa_q = '{32'h40000001, 32'h40000003, 32'h40000001, 32'hBFFFFFFF, 32'h7FFFFFFD};
    sb_q = '{32'h44000000, 32'h44000000, 32'h4C000000, 32'h44000000, 32'h40000000};
    for (int i = 0; i < 36; i++) begin
      sa_q.push_back($urandom);
      sb_q.push_back($urandom);
    end

    for (int i = 0; i < sa_q.size(); i++) begin
      logic        st;
      logic [31:0] er;
      bit          ei, ez;
      st = (i != 20);
      er = mmul(sa_q[i], sb_q[i], ei, ez);
      apply(sa_q[i], sb_q[i], st);
      chk($sformatf("stream%0d.res", i),  bus.result, er);
      chk($sformatf("stream%0d.inf", i),  {31'b0, bus.inf},  {31'b0, ei});
      chk($sformatf("stream%0d.zero", i), {31'b0, bus.zero}, {31'b0, ez});
      chk($sformatf("stream%0d.done", i), {31'b0, bus.done}, {31'b0, st});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/posit_mult_unit.md
Name: posit_mult_unit

Overview:
- Multiplies two posit numbers (default posit<32,2>) and returns the posit product, rounded to nearest with ties to even.
- Used as the multiply primitive in the PairHMM posit datapath.
- Datapath is combinational; the result is captured in one output register stage with a start/done qualifier.

Parameters:
- N, 32, posit word width in bits (≥8).
- Bs, log2(N) (5), width of regime run-length and shift-amount fields.
- es, 2, number of posit exponent bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in1  input  N  posit operand A.
- in2  input  N  posit operand B.
- start  input  1  operands valid this cycle.
- result  output  N  posit product (registered).
- inf  output  1  result is NaR (registered).
- zero  output  1  result is zero (registered).
- done  output  1  result/inf/zero valid (registered copy of start).

Behaviour:
- Reset: on a rising clk edge with rst=1, result, inf, zero and done all become 0. rst takes priority over start.
- Latency: exactly 1 cycle, fully pipelined.
  - Operands sampled with start=1 at edge t produce result/inf/zero and done=1 after edge t.
  - One new operation can be accepted every cycle.
  - When start=0, done=0 on the next cycle. result/inf/zero still register the datapath output for the current inputs.
- Special operands:
  - 0x0…0 is zero; 1 followed by N-1 zeros (0x80000000) is NaR.
  - If either operand is NaR: result=NaR, inf=1, zero=0. This includes 0×NaR.
  - Else if either operand is zero: result=0, zero=1, inf=0.
  - Otherwise inf=0 and zero=0. The multiply never rounds to 0 or to NaR.
- Decode of each operand:
  - sign = MSB. If the sign is set, take the two's complement of the word.
  - Regime: count the run of identical bits after the sign (leading-zero/one counter, Bs-bit count). A run of m ones gives k=m-1; a run of m zeros gives k=-m.
  - The next es bits are the exponent e, zero-padded if truncated.
  - Remaining bits form the fraction, with a hidden 1 prepended.
  - Scale = k·2^es + e, held signed with width Bs+es+2.
- Multiply:
  - sign = s1 XOR s2.
  - Scale = scale1 + scale2.
  - Mantissa product (two mantissas of N-es bits including the hidden bit) lies in [1,4). If it is ≥2, shift right by 1 and add 1 to the scale.
- Encode:
  - From the scale, derive k = scale >> es (arithmetic shift) and e = scale mod 2^es.
  - Regime bits: k≥0 gives (k+1) ones then a zero; k<0 gives -k zeros then a one.
  - Concatenate regime, e, and fraction bits, then right-shift to fit N-1 bits.
  - Round to nearest even using the guard bit plus the sticky OR of all discarded bits.
- Saturation:
  - A magnitude above maxpos (0x7FFFFFFF), or a round-up past it, gives maxpos.
  - A magnitude below minpos gives minpos (0x00000001).
- Sign: a negative result is the two's complement of the N-bit magnitude word.
- No internal state besides the output registers. X-free outputs after reset.

Test Plan:
- Reset, then start=1 with in1=in2=0x40000000 (1.0×1.0): next cycle result=0x40000000, done=1, inf=0, zero=0. Asserting rst mid-stream clears all outputs on the next edge.
- 0x48000000×0x48000000 (2×2) → 0x50000000. 0x44000000×0x44000000 (1.5×1.5) → 0x49000000. 0xC0000000×0x48000000 (-1×2) → 0xB8000000.
- Saturation: 0x7FFFFFFF×0x7FFFFFFF → 0x7FFFFFFF. 0x00000001×0x00000001 → 0x00000001. Neither case raises zero or inf.
- Specials: 0x00000000×0x48000000 → 0x00000000 with zero=1. 0x80000000×0x00000000 → 0x80000000 with inf=1, zero=0. 0x80000000×0x40000000 → NaR with inf=1.
- Back-to-back: a random operand stream with start=1 every cycle. Each cycle's result matches a bit-exact posit<32,2> golden model of the previous cycle's operands. The check must include tie-to-even cases (guard=1, sticky=0).
- Deassert start for one cycle mid-stream → done=0 for exactly that one cycle; the results around the gap stay correct.
